// File: rtl/mem_arbiter_if.sv
// Bundle between the arbiter, its three requesters and the shared memory port.
// The arbiter takes the slave view; the requester/memory side takes the master view.
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              d_req;
    logic [ADDR_W-1:0] d_addr;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_valid;
    logic              mem_en;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              i_valid;
    logic              d_valid;
    logic [DATA_W-1:0] rdata;
    logic              i_busy;
    logic              d_busy;
    logic              wr_ack;

    modport slave (
        input  i_req, i_addr, d_req, d_addr, wr_req, wr_addr, wr_data,
               mem_rdata, mem_valid,
        output mem_en, mem_wr, mem_addr, mem_wdata, i_valid, d_valid, rdata,
               i_busy, d_busy, wr_ack
    );

    modport master (
        output i_req, i_addr, d_req, d_addr, wr_req, wr_addr, wr_data,
               mem_rdata, mem_valid,
        input  mem_en, mem_wr, mem_addr, mem_wdata, i_valid, d_valid, rdata,
               i_busy, d_busy, wr_ack
    );
endinterface

// File: rtl/mem_arbiter.sv
// Fixed-priority arbiter for one multicycle memory port: stores > D-fill > I-fill.
// A fill owns the port for a whole line; aborted fills drain their outstanding reads.
module mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int BEATS  = 8
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    localparam logic [3:0] BEATS_C = 4'(BEATS);

    typedef enum logic [2:0] {IDLE, I_FILL, D_FILL, WRITE, DRAIN} state_e;

    state_e     state_q, state_d;
    logic [3:0] issued_q, issued_d;
    logic [3:0] returned_q, returned_d;

    logic       fill, issue, owner_req;
    logic [3:0] ret_inc;

    assign fill      = (state_q == I_FILL) || (state_q == D_FILL);
    assign issue     = fill && (issued_q < BEATS_C);
    assign owner_req = (state_q == I_FILL) ? bus.i_req : bus.d_req;
    assign ret_inc   = returned_q + {3'b000, bus.mem_valid};

    always_comb begin
        state_d    = state_q;
        issued_d   = issued_q;
        returned_d = returned_q;
        case (state_q)
            IDLE: begin
                issued_d   = '0;
                returned_d = '0;
                if (bus.wr_req)     state_d = WRITE;
                else if (bus.d_req) state_d = D_FILL;
                else if (bus.i_req) state_d = I_FILL;
            end
            WRITE: state_d = IDLE;
            I_FILL, D_FILL: begin
                issued_d   = issued_q + {3'b000, issue};
                returned_d = ret_inc;
                if (ret_inc == BEATS_C) begin
                    state_d    = IDLE;
                    issued_d   = '0;
                    returned_d = '0;
                end else if (!owner_req) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                returned_d = ret_inc;
                // Reads issued before the abort still return; swallow them all.
                if (ret_inc >= issued_q) begin
                    state_d    = IDLE;
                    issued_d   = '0;
                    returned_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            issued_q   <= '0;
            returned_q <= '0;
        end else begin
            state_q    <= state_d;
            issued_q   <= issued_d;
            returned_q <= returned_d;
        end
    end

    logic [ADDR_W-1:0] addr_o;
    logic [DATA_W-1:0] wdata_o;

    always_comb begin
        addr_o       = '0;
        wdata_o      = '0;
        bus.mem_en   = 1'b0;
        bus.mem_wr   = 1'b0;
        bus.i_valid  = 1'b0;
        bus.d_valid  = 1'b0;
        bus.wr_ack   = 1'b0;
        bus.i_busy   = bus.i_req;
        bus.d_busy   = bus.d_req;
        // While reset is held every requester stays blocked and the port is quiet.
        if (!rst) begin
            case (state_q)
                WRITE: begin
                    bus.mem_en = 1'b1;
                    bus.mem_wr = 1'b1;
                    addr_o     = bus.wr_addr;
                    wdata_o    = bus.wr_data;
                    bus.wr_ack = 1'b1;
                end
                I_FILL: begin
                    bus.mem_en  = issue;
                    addr_o      = bus.i_addr;
                    bus.i_valid = bus.mem_valid;
                    bus.i_busy  = 1'b0;
                end
                D_FILL: begin
                    bus.mem_en  = issue;
                    addr_o      = bus.d_addr;
                    bus.d_valid = bus.mem_valid;
                    bus.d_busy  = 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_addr  = addr_o;
    assign bus.mem_wdata = wdata_o;
    assign bus.rdata     = bus.mem_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fills, priority, write-behind, abort/drain and reset.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    mem_arbiter_if bus ();

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .BEATS(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts in the first cycle of a fill; returns in the IDLE cycle after the 8th beat.
    task automatic run_fill(input bit is_d, input logic [15:0] addr, input string tag);
        logic mv, own_v, oth_v, own_b, oth_b, oth_r;
        for (int k = 0; k < 12; k++) begin
            mv = (k >= 4);
            bus.mem_valid = mv;
            bus.mem_rdata = 16'(k * 16'h0111);
            #1;
            own_v = is_d ? bus.d_valid : bus.i_valid;
            oth_v = is_d ? bus.i_valid : bus.d_valid;
            own_b = is_d ? bus.d_busy : bus.i_busy;
            oth_b = is_d ? bus.i_busy : bus.d_busy;
            oth_r = is_d ? bus.i_req : bus.d_req;
            n_cmp++; if (bus.mem_en !== (k < 8)) begin n_bad++; $display("FAIL %s_mem_en k=%0d got=%b exp=%b", tag, k, bus.mem_en, (k < 8)); end
            if (k < 8) begin
                n_cmp++; if (bus.mem_addr !== addr || bus.mem_wr !== 1'b0) begin n_bad++; $display("FAIL %s_addr k=%0d got=%h/%b exp=%h/0", tag, k, bus.mem_addr, bus.mem_wr, addr); end
            end
            n_cmp++; if (own_v !== mv || oth_v !== 1'b0) begin n_bad++; $display("FAIL %s_valid k=%0d got=%b/%b exp=%b/0", tag, k, own_v, oth_v, mv); end
            n_cmp++; if (own_b !== 1'b0 || oth_b !== oth_r) begin n_bad++; $display("FAIL %s_busy k=%0d got=%b/%b exp=0/%b", tag, k, own_b, oth_b, oth_r); end
            n_cmp++; if (bus.rdata !== 16'(k * 16'h0111)) begin n_bad++; $display("FAIL %s_rdata k=%0d got=%h exp=%h", tag, k, bus.rdata, 16'(k * 16'h0111)); end
            step();
        end
        bus.mem_valid = 1'b0;
        if (is_d) bus.d_req = 1'b0; else bus.i_req = 1'b0;
        #1;
        n_cmp++; if (bus.mem_en !== 1'b0 || bus.i_valid !== 1'b0 || bus.d_valid !== 1'b0) begin n_bad++; $display("FAIL %s_end got en=%b iv=%b dv=%b exp=0", tag, bus.mem_en, bus.i_valid, bus.d_valid); end
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.i_req = 1'b1; bus.mem_valid = 1'b1; bus.mem_rdata = 16'h5A5A;
        step();
        n_cmp++; if (bus.mem_en !== 1'b0 || bus.mem_wr !== 1'b0 || bus.mem_addr !== 16'h0 || bus.mem_wdata !== 16'h0) begin n_bad++; $display("FAIL rst_port got en=%b wr=%b a=%h d=%h exp=0", bus.mem_en, bus.mem_wr, bus.mem_addr, bus.mem_wdata); end
        n_cmp++; if (bus.i_valid !== 1'b0 || bus.d_valid !== 1'b0 || bus.wr_ack !== 1'b0) begin n_bad++; $display("FAIL rst_valid got iv=%b dv=%b ack=%b exp=0", bus.i_valid, bus.d_valid, bus.wr_ack); end
        n_cmp++; if (bus.i_busy !== 1'b1 || bus.d_busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got i=%b d=%b exp=1/0", bus.i_busy, bus.d_busy); end
        n_cmp++; if (bus.rdata !== 16'h5A5A) begin n_bad++; $display("FAIL rst_rdata got=%h exp=5a5a", bus.rdata); end
        bus.i_req = 1'b0; bus.mem_valid = 1'b0;
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_i_fill();
        bus.i_req = 1'b1; bus.i_addr = 16'h1230;
        #1;
        n_cmp++; if (bus.mem_en !== 1'b0 || bus.i_busy !== 1'b1) begin n_bad++; $display("FAIL ifill_grant_lat got en=%b busy=%b exp=0/1", bus.mem_en, bus.i_busy); end
        step();
        run_fill(1'b0, 16'h1230, "ifill");
        n_cmp++; if (bus.i_busy !== 1'b0) begin n_bad++; $display("FAIL ifill_idle_busy got=%b exp=0", bus.i_busy); end
        step();
        n_cmp++; if (bus.mem_en !== 1'b0) begin n_bad++; $display("FAIL ifill_stay_idle got=%b exp=0", bus.mem_en); end
    endtask

    task automatic test_priority();
        bus.i_req = 1'b1; bus.d_req = 1'b1; bus.i_addr = 16'h1230; bus.d_addr = 16'h4560;
        step();
        run_fill(1'b1, 16'h4560, "prio_d");
        n_cmp++; if (bus.i_busy !== 1'b1) begin n_bad++; $display("FAIL prio_gap_busy got=%b exp=1", bus.i_busy); end
        step();
        n_cmp++; if (bus.mem_en !== 1'b1 || bus.mem_addr !== 16'h1230 || bus.i_busy !== 1'b0) begin n_bad++; $display("FAIL prio_i_grant got en=%b a=%h b=%b exp=1/1230/0", bus.mem_en, bus.mem_addr, bus.i_busy); end
        run_fill(1'b0, 16'h1230, "prio_i");
    endtask

    task automatic test_write_during_fill();
        bus.i_req = 1'b1; bus.i_addr = 16'h1230;
        step();
        for (int k = 0; k < 9; k++) begin
            bus.mem_valid = (k >= 1);
            if (k == 4) begin bus.wr_req = 1'b1; bus.wr_addr = 16'h00A4; bus.wr_data = 16'hBEEF; end
            #1;
            n_cmp++; if (bus.wr_ack !== 1'b0 || bus.mem_wr !== 1'b0) begin n_bad++; $display("FAIL wr_wait k=%0d got ack=%b wr=%b exp=0", k, bus.wr_ack, bus.mem_wr); end
            step();
        end
        bus.mem_valid = 1'b0; bus.i_req = 1'b0;
        #1;
        n_cmp++; if (bus.wr_ack !== 1'b0 || bus.mem_en !== 1'b0) begin n_bad++; $display("FAIL wr_gap got ack=%b en=%b exp=0", bus.wr_ack, bus.mem_en); end
        step();
        n_cmp++; if (bus.mem_en !== 1'b1 || bus.mem_wr !== 1'b1 || bus.mem_addr !== 16'h00A4 || bus.mem_wdata !== 16'hBEEF || bus.wr_ack !== 1'b1) begin n_bad++; $display("FAIL wr_cycle got en=%b wr=%b a=%h d=%h ack=%b exp=1/1/00a4/beef/1", bus.mem_en, bus.mem_wr, bus.mem_addr, bus.mem_wdata, bus.wr_ack); end
        bus.wr_req = 1'b0;
        step();
        n_cmp++; if (bus.wr_ack !== 1'b0 || bus.mem_en !== 1'b0) begin n_bad++; $display("FAIL wr_pulse got ack=%b en=%b exp=0", bus.wr_ack, bus.mem_en); end
    endtask

    task automatic test_wr_and_d();
        bus.wr_req = 1'b1; bus.d_req = 1'b1; bus.wr_addr = 16'h0010; bus.wr_data = 16'h1111; bus.d_addr = 16'h7770;
        step();
        n_cmp++; if (bus.wr_ack !== 1'b1 || bus.mem_wr !== 1'b1 || bus.d_busy !== 1'b1) begin n_bad++; $display("FAIL wrd_write got ack=%b wr=%b db=%b exp=1/1/1", bus.wr_ack, bus.mem_wr, bus.d_busy); end
        bus.wr_req = 1'b0;
        step();
        n_cmp++; if (bus.mem_en !== 1'b0 || bus.wr_ack !== 1'b0 || bus.d_busy !== 1'b1) begin n_bad++; $display("FAIL wrd_gap got en=%b ack=%b db=%b exp=0/0/1", bus.mem_en, bus.wr_ack, bus.d_busy); end
        step();
        run_fill(1'b1, 16'h7770, "wrd_d");
    endtask

    task automatic test_abort();
        bus.d_req = 1'b1; bus.d_addr = 16'h4560;
        step();
        for (int k = 0; k < 5; k++) begin
            bus.mem_valid = (k == 3 || k == 4);
            if (k == 4) begin bus.d_req = 1'b0; bus.i_req = 1'b1; bus.i_addr = 16'h2220; end
            #1;
            n_cmp++; if (bus.mem_en !== 1'b1 || bus.d_valid !== bus.mem_valid) begin n_bad++; $display("FAIL abort_fill k=%0d got en=%b dv=%b exp=1/%b", k, bus.mem_en, bus.d_valid, bus.mem_valid); end
            step();
        end
        for (int j = 0; j < 3; j++) begin
            bus.mem_valid = 1'b1;
            #1;
            n_cmp++; if (bus.mem_en !== 1'b0 || bus.d_valid !== 1'b0 || bus.i_valid !== 1'b0 || bus.i_busy !== 1'b1) begin n_bad++; $display("FAIL abort_drain j=%0d got en=%b dv=%b iv=%b ib=%b exp=0/0/0/1", j, bus.mem_en, bus.d_valid, bus.i_valid, bus.i_busy); end
            step();
        end
        bus.mem_valid = 1'b0;
        #1;
        n_cmp++; if (bus.mem_en !== 1'b0 || bus.i_busy !== 1'b1) begin n_bad++; $display("FAIL abort_idle got en=%b ib=%b exp=0/1", bus.mem_en, bus.i_busy); end
        step();
        run_fill(1'b0, 16'h2220, "abort_i");
    endtask

    task automatic test_reset_mid_fill();
        bus.d_req = 1'b1; bus.d_addr = 16'h3330;
        step();
        for (int k = 0; k < 6; k++) begin
            bus.mem_valid = (k == 4);
            step();
        end
        bus.mem_valid = 1'b0; rst = 1'b1; bus.d_req = 1'b0;
        step();
        rst = 1'b0;
        for (int j = 0; j < 3; j++) begin
            bus.mem_valid = 1'b1;
            #1;
            n_cmp++; if (bus.mem_en !== 1'b0 || bus.d_valid !== 1'b0 || bus.i_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_late j=%0d got en=%b dv=%b iv=%b exp=0", j, bus.mem_en, bus.d_valid, bus.i_valid); end
            step();
        end
        bus.mem_valid = 1'b0; bus.d_req = 1'b1;
        step();
        run_fill(1'b1, 16'h3330, "rstmid_d");
    endtask

    task automatic test_idle_valid();
        for (int j = 0; j < 2; j++) begin
            bus.mem_valid = 1'b1;
            #1;
            n_cmp++; if (bus.i_valid !== 1'b0 || bus.d_valid !== 1'b0 || bus.mem_en !== 1'b0 || bus.wr_ack !== 1'b0) begin n_bad++; $display("FAIL idle_valid j=%0d got iv=%b dv=%b en=%b ack=%b exp=0", j, bus.i_valid, bus.d_valid, bus.mem_en, bus.wr_ack); end
            step();
        end
        bus.mem_valid = 1'b0; bus.i_req = 1'b1; bus.i_addr = 16'h0040;
        #1;
        n_cmp++; if (bus.mem_en !== 1'b0) begin n_bad++; $display("FAIL idle_still got en=%b exp=0", bus.mem_en); end
        step();
        run_fill(1'b0, 16'h0040, "idle_i");
    endtask

    initial begin
        bus.i_req = 1'b0; bus.i_addr = '0; bus.d_req = 1'b0; bus.d_addr = '0;
        bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.mem_rdata = '0; bus.mem_valid = 1'b0;
        test_reset();
        test_i_fill();
        test_priority();
        test_write_during_fill();
        test_wr_and_d();
        test_abort();
        test_reset_mid_fill();
        test_idle_valid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
